// File: rtl/dpram_arbiter_if.sv
// -----------------------------------------------------------------------------
// dpram_arbiter_if
// One requester's connection to dpram_arbiter.
//   valid      requester -> arbiter  request present (held until ack)
//   write      requester -> arbiter  1 = write, 0 = read
//   addr       requester -> arbiter  request address
//   wdata      requester -> arbiter  write data
//   ack        arbiter -> requester  request accepted this cycle (combinational)
//   rsp_valid  arbiter -> requester  read data for this requester valid
//   rsp_data   arbiter -> requester  read data
// -----------------------------------------------------------------------------
interface dpram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (output valid, write, addr, wdata,
                    input  ack, rsp_valid, rsp_data);
    modport slave  (input  valid, write, addr, wdata,
                    output ack, rsp_valid, rsp_data);
endinterface

// File: rtl/dpram_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_arbiter
// Shares one dual-port RAM (one write port, one registered read port) between
// two requesters. Writes and reads each have their own round-robin pointer, so
// one write and one read can issue per cycle.
//   clk            sole clock (also clocks the RAM externally)
//   rst            synchronous reset, active-high
//   req0, req1     requester interfaces (slave side)
//   ram_wr_addr_o  RAM write address (registered)
//   ram_wr_en_o    RAM write enable, one-cycle pulse per write (registered)
//   ram_wr_data_o  RAM write data (registered)
//   ram_rd_addr_o  RAM read address (registered, holds when idle)
//   ram_rd_data_i  RAM read data, valid two cycles after the read ack
// -----------------------------------------------------------------------------
module dpram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dpram_arbiter_if.slave        req0,
    dpram_arbiter_if.slave        req1,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic                  ram_wr_en_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

    logic                  wr_last_q, wr_last_d;
    logic                  rd_last_q, rd_last_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  tag1_v_q, tag1_v_d, tag1_o_q, tag1_o_d;
    logic                  tag2_v_q, tag2_o_q;

    logic                  wr_cand0, wr_cand1, rd_cand0, rd_cand1;
    logic                  wr_any, rd_any, wr_sel, rd_sel;
    logic                  wr_fire, rd_fire, rd_hazard;
    logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
    logic [DATA_WIDTH-1:0] wr_data_sel;

    // Fields of an idle requester are never looked at: every use is gated by valid.
    assign wr_cand0 = req0.valid && req0.write;
    assign wr_cand1 = req1.valid && req1.write;
    assign rd_cand0 = req0.valid && !req0.write;
    assign rd_cand1 = req1.valid && !req1.write;

    assign wr_any = wr_cand0 || wr_cand1;
    assign rd_any = rd_cand0 || rd_cand1;

    // On a tie, grant the requester that did not win the previous grant.
    assign wr_sel = (wr_cand0 && wr_cand1) ? !wr_last_q : wr_cand1;
    assign rd_sel = (rd_cand0 && rd_cand1) ? !rd_last_q : rd_cand1;

    assign wr_addr_sel = wr_sel ? req1.addr  : req0.addr;
    assign wr_data_sel = wr_sel ? req1.wdata : req0.wdata;
    assign rd_addr_sel = rd_sel ? req1.addr  : req0.addr;

    // A read colliding with this cycle's write or with the write still sitting
    // in the RAM write register is held off, so it always returns the new data.
    assign rd_hazard = rd_any &&
                       ((wr_any && (rd_addr_sel == wr_addr_sel)) ||
                        (wr_en_q && (rd_addr_sel == wr_addr_q)));

    assign wr_fire = wr_any && !rst;
    assign rd_fire = rd_any && !rd_hazard && !rst;

    assign req0.ack = (wr_fire && !wr_sel) || (rd_fire && !rd_sel);
    assign req1.ack = (wr_fire &&  wr_sel) || (rd_fire &&  rd_sel);

    always_comb begin
        wr_last_d = wr_last_q;
        rd_last_d = rd_last_q;
        wr_en_d   = wr_fire;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        tag1_v_d  = rd_fire;
        tag1_o_d  = rd_sel;
        if (wr_fire) begin
            wr_last_d = wr_sel;
            wr_addr_d = wr_addr_sel;
            wr_data_d = wr_data_sel;
        end
        if (rd_fire) begin
            rd_last_d = rd_sel;
            rd_addr_d = rd_addr_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_last_q <= 1'b1;
            rd_last_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            tag1_v_q  <= 1'b0;
            tag1_o_q  <= 1'b0;
            tag2_v_q  <= 1'b0;
            tag2_o_q  <= 1'b0;
        end else begin
            wr_last_q <= wr_last_d;
            rd_last_q <= rd_last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            tag1_v_q  <= tag1_v_d;
            tag1_o_q  <= tag1_o_d;
            tag2_v_q  <= tag1_v_q;
            tag2_o_q  <= tag1_o_q;
        end
    end

    assign ram_wr_en_o   = wr_en_q;
    assign ram_wr_addr_o = wr_addr_q;
    assign ram_wr_data_o = wr_data_q;
    assign ram_rd_addr_o = rd_addr_q;

    // Read data passes straight through; only the owner's valid is raised.
    assign req0.rsp_valid = tag2_v_q && !tag2_o_q;
    assign req1.rsp_valid = tag2_v_q &&  tag2_o_q;
    assign req0.rsp_data  = ram_rd_data_i;
    assign req1.rsp_data  = ram_rd_data_i;

endmodule

// File: tb/tb_dpram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_arbiter
// Directed bench for dpram_arbiter. Provides a behavioural dual-port RAM
// (registered read, preloaded with addr ^ 8'h3C) and checks acks, RAM write
// port pulses and read responses against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dpram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data;
    logic       ram_wr_en;
    logic [7:0] mem [256];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    dpram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) req0_if ();
    dpram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) req1_if ();

    dpram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0_if),
        .req1          (req1_if),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_en_o   (ram_wr_en),
        .ram_wr_data_o (ram_wr_data),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data)
    );

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = 8'h33; req0_if.wdata = 8'h99;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_vec++; if (req0_if.ack !== 1'b0) begin n_err++; $display("FAIL reset_ack0 got=%0b exp=0", req0_if.ack); end
        n_vec++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%0b exp=0", ram_wr_en); end
        n_vec++; if (ram_wr_addr !== 8'h00 || ram_wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_bus got=%h/%h exp=00/00", ram_wr_addr, ram_wr_data); end
        n_vec++; if (ram_rd_addr !== 8'h00) begin n_err++; $display("FAIL reset_rd_addr got=%h exp=00", ram_rd_addr); end
        n_vec++; if (req0_if.rsp_valid !== 1'b0 || req1_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp got=%0b%0b exp=00", req0_if.rsp_valid, req1_if.rsp_valid); end
        next_cycle();
        rst = 1'b0;
        req0_if.valid = 1'b0;
    endtask

    task automatic test_basic(input logic [7:0] a, input logic [7:0] d);
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = a; req0_if.wdata = d;
        @(negedge clk);
        n_vec++; if (req0_if.ack !== 1'b1 || req1_if.ack !== 1'b0) begin n_err++; $display("FAIL basic_wr_ack got=%0b%0b exp=10", req0_if.ack, req1_if.ack); end
        next_cycle();
        req0_if.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== a || ram_wr_data !== d) begin n_err++; $display("FAIL basic_wr_port got=%0b/%h/%h exp=1/%h/%h", ram_wr_en, ram_wr_addr, ram_wr_data, a, d); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL basic_wr_pulse got=%0b exp=0", ram_wr_en); end
        next_cycle();
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = a; req0_if.wdata = 8'hxx;
        @(negedge clk);
        n_vec++; if (req0_if.ack !== 1'b1) begin n_err++; $display("FAIL basic_rd_ack got=%0b exp=1", req0_if.ack); end
        next_cycle();
        req0_if.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (req0_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_rsp_early got=%0b exp=0", req0_if.rsp_valid); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (req0_if.rsp_valid !== 1'b1 || req1_if.rsp_valid !== 1'b0 || req0_if.rsp_data !== d) begin n_err++; $display("FAIL basic_rsp got=%0b%0b/%h exp=10/%h", req0_if.rsp_valid, req1_if.rsp_valid, req0_if.rsp_data, d); end
        next_cycle();
    endtask

    task automatic test_back_to_back_writes();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = 8'h01; req0_if.wdata = 8'h11;
        req1_if.valid = 1'b1; req1_if.write = 1'b1; req1_if.addr = 8'h02; req1_if.wdata = 8'h22;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++; if (req0_if.ack !== (i % 2 == 0) || req1_if.ack !== (i % 2 == 1)) begin n_err++; $display("FAIL b2b_ack[%0d] got=%0b%0b exp=%0b%0b", i, req0_if.ack, req1_if.ack, (i % 2 == 0), (i % 2 == 1)); end
            if (i >= 1) begin
                n_vec++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== ((i % 2 == 1) ? 8'h01 : 8'h02)) begin n_err++; $display("FAIL b2b_wr[%0d] got=%0b/%h", i, ram_wr_en, ram_wr_addr); end
            end
            next_cycle();
        end
        req0_if.valid = 1'b0; req1_if.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 8'h02 || ram_wr_data !== 8'h22) begin n_err++; $display("FAIL b2b_last_wr got=%0b/%h/%h exp=1/02/22", ram_wr_en, ram_wr_addr, ram_wr_data); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (ram_wr_en !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%0b exp=0", ram_wr_en); end
        next_cycle();
    endtask

    task automatic test_parallel_rw();
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = 8'h20; req0_if.wdata = 8'h5A;
        req1_if.valid = 1'b1; req1_if.write = 1'b0; req1_if.addr = 8'h30; req1_if.wdata = 8'hxx;
        @(negedge clk);
        n_vec++; if (req0_if.ack !== 1'b1 || req1_if.ack !== 1'b1) begin n_err++; $display("FAIL par_ack got=%0b%0b exp=11", req0_if.ack, req1_if.ack); end
        next_cycle();
        req0_if.valid = 1'b0; req1_if.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (req0_if.rsp_valid !== 1'b0 || req1_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL par_rsp_early got=%0b%0b exp=00", req0_if.rsp_valid, req1_if.rsp_valid); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (req0_if.rsp_valid !== 1'b0 || req1_if.rsp_valid !== 1'b1 || req1_if.rsp_data !== 8'h0C) begin n_err++; $display("FAIL par_rsp got=%0b%0b/%h exp=01/0c", req0_if.rsp_valid, req1_if.rsp_valid, req1_if.rsp_data); end
        next_cycle();
    endtask

    task automatic test_hazard();
        req0_if.valid = 1'b1; req0_if.write = 1'b1; req0_if.addr = 8'h40; req0_if.wdata = 8'h77;
        req1_if.valid = 1'b1; req1_if.write = 1'b0; req1_if.addr = 8'h40; req1_if.wdata = 8'hxx;
        @(negedge clk);
        n_vec++; if (req0_if.ack !== 1'b1 || req1_if.ack !== 1'b0) begin n_err++; $display("FAIL haz_n got=%0b%0b exp=10", req0_if.ack, req1_if.ack); end
        next_cycle();
        req0_if.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (req1_if.ack !== 1'b0) begin n_err++; $display("FAIL haz_n1 got=%0b exp=0", req1_if.ack); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (req1_if.ack !== 1'b1) begin n_err++; $display("FAIL haz_n2 got=%0b exp=1", req1_if.ack); end
        next_cycle();
        req1_if.valid = 1'b0;
        next_cycle();
        @(negedge clk);
        n_vec++; if (req1_if.rsp_valid !== 1'b1 || req0_if.rsp_valid !== 1'b0 || req1_if.rsp_data !== 8'h77) begin n_err++; $display("FAIL haz_rsp got=%0b%0b/%h exp=01/77", req0_if.rsp_valid, req1_if.rsp_valid, req1_if.rsp_data); end
        next_cycle();
    endtask

    task automatic test_back_to_back_reads();
        int n0 = 0;
        int n1 = 0;
        req0_if.write = 1'b0; req1_if.write = 1'b0;
        for (int c = 0; c < 18; c++) begin
            req0_if.valid = (n0 < 8); req0_if.addr = 8'(8'h80 + n0);
            req1_if.valid = (n1 < 8); req1_if.addr = 8'(8'h90 + n1);
            @(negedge clk);
            if (c < 16) begin
                n_vec++; if (req0_if.ack !== (c % 2 == 0) || req1_if.ack !== (c % 2 == 1)) begin n_err++; $display("FAIL rd_b2b_ack[%0d] got=%0b%0b", c, req0_if.ack, req1_if.ack); end
            end
            if (c >= 2) begin
                automatic int         o  = (c - 2) % 2;
                automatic logic [7:0] ea = 8'((o == 1 ? 8'h90 : 8'h80) + (c - 2) / 2);
                n_vec++; if (req0_if.rsp_valid !== (o == 0) || req1_if.rsp_valid !== (o == 1) || req0_if.rsp_data !== (ea ^ 8'h3C)) begin n_err++; $display("FAIL rd_b2b_rsp[%0d] got=%0b%0b/%h exp owner=%0d data=%h", c, req0_if.rsp_valid, req1_if.rsp_valid, req0_if.rsp_data, o, ea ^ 8'h3C); end
            end
            if (req0_if.ack === 1'b1) n0++;
            if (req1_if.ack === 1'b1) n1++;
            next_cycle();
        end
        req0_if.valid = 1'b0; req1_if.valid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        req0_if.valid = 1'b1; req0_if.write = 1'b0; req0_if.addr = 8'h50;
        @(negedge clk);
        n_vec++; if (req0_if.ack !== 1'b1) begin n_err++; $display("FAIL rst_rd_ack got=%0b exp=1", req0_if.ack); end
        next_cycle();
        req0_if.valid = 1'b0;
        rst = 1'b1;
        req1_if.valid = 1'b1; req1_if.write = 1'b1; req1_if.addr = 8'h60; req1_if.wdata = 8'hEE;
        @(negedge clk);
        n_vec++; if (req1_if.ack !== 1'b0) begin n_err++; $display("FAIL rst_ack1 got=%0b exp=0", req1_if.ack); end
        next_cycle();
        rst = 1'b0;
        req1_if.valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ram_wr_en !== 1'b0 || ram_wr_addr !== 8'h00 || ram_wr_data !== 8'h00 || ram_rd_addr !== 8'h00) begin n_err++; $display("FAIL rst_outputs got=%0b/%h/%h/%h exp=0/00/00/00", ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (req0_if.rsp_valid !== 1'b0 || req1_if.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_rsp[%0d] got=%0b%0b exp=00", k, req0_if.rsp_valid, req1_if.rsp_valid); end
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        test_basic(8'h11, 8'hC3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        rst = 1'b1;
        req0_if.valid = 1'b0; req0_if.write = 1'bx; req0_if.addr = 8'hxx; req0_if.wdata = 8'hxx;
        req1_if.valid = 1'b0; req1_if.write = 1'bx; req1_if.addr = 8'hxx; req1_if.wdata = 8'hxx;
        #1;
        test_reset();
        test_basic(8'h10, 8'hA5);
        test_back_to_back_writes();
        test_parallel_rw();
        test_hazard();
        test_back_to_back_reads();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
